// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops land in a one-entry output register; MUL runs
// as a WIDTH-step shift-add and is written through the same register.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             CLK_s,
  input  logic             RST_s,
  input  logic             Enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Data_A,
  input  logic [WIDTH-1:0] Data_B,
  input  logic [3:0]       Opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Results,
  output logic [WIDTH-1:0] Results_hi,
  output logic             CF,
  output logic             ZF,
  output logic             NF,
  output logic             VF,
  output logic             ERR
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8, OP_ADC = 4'h9, OP_CMP = 4'hA, OP_MUL = 4'hB;
  localparam logic [3:0] OP_PASS = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WRITE} state_t;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a, b, s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a, b, d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  state_t                state_q, state_d;
  logic                  carry_q;
  logic [CW-1:0]         cnt_q;
  logic [WIDTH-1:0]      mcand_p0;
  logic [2*WIDTH-1:0]    prod_p0;
  logic [WIDTH:0]        step_w;
  logic                  out_free, accept, ld_single, ld_mul;

  logic [SW-1:0]         amt;
  logic                  cin;
  logic [WIDTH:0]        sum_w, dif_w, shl_w, shr_w;
  logic signed [WIDTH:0] a_ext_s, sra_w;
  logic [WIDTH-1:0]      res_c, flag_v;
  logic                  cf_c, zf_c, nf_c, vf_c, err_c;

  // Stage p0: single-cycle operation decode
  always_comb begin
    amt     = Data_B[SW-1:0];
    cin     = (Opcode == OP_ADC) ? carry_q : 1'b0;
    sum_w   = {1'b0, Data_A} + {1'b0, Data_B} + {{WIDTH{1'b0}}, cin};
    dif_w   = {1'b0, Data_A} - {1'b0, Data_B};
    // Shifts run one bit wider so the last bit shifted out falls into the spare bit
    shl_w   = {1'b0, Data_A} << amt;
    shr_w   = {Data_A, 1'b0} >> amt;
    a_ext_s = {Data_A, 1'b0};
    sra_w   = a_ext_s >>> amt;
    res_c   = '0;
    cf_c    = 1'b0;
    vf_c    = 1'b0;
    err_c   = 1'b0;
    case (Opcode)
      OP_ADD, OP_ADC: begin
        res_c = sum_w[WIDTH-1:0];
        cf_c  = sum_w[WIDTH];
        vf_c  = add_ovf(Data_A, Data_B, sum_w[WIDTH-1:0]);
      end
      OP_SUB, OP_CMP: begin
        res_c = (Opcode == OP_SUB) ? dif_w[WIDTH-1:0] : '0;
        cf_c  = dif_w[WIDTH];
        vf_c  = sub_ovf(Data_A, Data_B, dif_w[WIDTH-1:0]);
      end
      OP_AND:  res_c = Data_A & Data_B;
      OP_OR:   res_c = Data_A | Data_B;
      OP_XOR:  res_c = Data_A ^ Data_B;
      OP_NOT:  res_c = ~Data_A;
      OP_SHL: begin
        res_c = shl_w[WIDTH-1:0];
        cf_c  = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_c = shr_w[WIDTH:1];
        cf_c  = shr_w[0];
      end
      OP_SRA: begin
        res_c = sra_w[WIDTH:1];
        cf_c  = sra_w[0];
      end
      OP_PASS: res_c = Data_B;
      OP_MUL:  res_c = '0;
      default: err_c = 1'b1;
    endcase
    flag_v = (Opcode == OP_CMP) ? dif_w[WIDTH-1:0] : res_c;
    zf_c   = !err_c && (flag_v == '0);
    nf_c   = flag_v[WIDTH-1];
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    out_free = !out_valid || out_ready;
    case (state_q)
      S_IDLE: begin
        in_ready = Enable && out_free;
        if (in_valid && in_ready && Opcode == OP_MUL) state_d = S_MUL;
      end
      S_MUL:   if (Enable && cnt_q == CW'(1)) state_d = S_WRITE;
      S_WRITE: if (out_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign ld_single = accept && (Opcode != OP_MUL);
  assign ld_mul    = (state_q == S_WRITE) && out_free;
  assign step_w    = {1'b0, prod_p0[2*WIDTH-1:WIDTH]} +
                     (prod_p0[0] ? {1'b0, mcand_p0} : {(WIDTH+1){1'b0}});

  always_ff @(posedge CLK_s or posedge RST_s) begin
    if (RST_s) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && Opcode == OP_MUL) cnt_q <= CW'(WIDTH);
      else if (state_q == S_MUL && Enable) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Stage p1: iterative multiply, low half of prod_p0 starts as the multiplier
  always_ff @(posedge CLK_s) begin
    if (accept && Opcode == OP_MUL) begin
      mcand_p0 <= Data_A;
      prod_p0  <= {{WIDTH{1'b0}}, Data_B};
    end else if (state_q == S_MUL && Enable) begin
      prod_p0  <= {step_w, prod_p0[WIDTH-1:1]};
    end
  end

  // Stage p2: output register
  always_ff @(posedge CLK_s or posedge RST_s) begin
    if (RST_s) begin
      out_valid  <= 1'b0;
      Results    <= '0;
      Results_hi <= '0;
      {CF, ZF, NF, VF, ERR} <= '0;
      carry_q    <= 1'b0;
    end else if (ld_single) begin
      out_valid  <= 1'b1;
      Results    <= res_c;
      Results_hi <= '0;
      {CF, ZF, NF, VF, ERR} <= {cf_c, zf_c, nf_c, vf_c, err_c};
      carry_q    <= cf_c;
    end else if (ld_mul) begin
      out_valid  <= 1'b1;
      Results    <= prod_p0[WIDTH-1:0];
      Results_hi <= prod_p0[2*WIDTH-1:WIDTH];
      CF         <= |prod_p0[2*WIDTH-1:WIDTH];
      ZF         <= (prod_p0 == '0);
      NF         <= prod_p0[WIDTH-1];
      VF         <= 1'b0;
      ERR        <= 1'b0;
      carry_q    <= |prod_p0[2*WIDTH-1:WIDTH];
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
